// File: rtl/comparator_bist_pkg.sv
// comparator_bist_pkg
// Shared definitions for the comparator BIST engine: the sequencer state
// encoding, the default operand width and the error-counter ceiling.
package comparator_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          WIDTH_DEF = 16;
  localparam logic [15:0] ERR_MAX   = 16'hFFFF;

endpackage

// File: rtl/bist_vec_gen.sv
// bist_vec_gen
// Operand generator for the comparator BIST. Holds the A/B operand registers
// that drive the comparator under test. A counts down and B counts up, both
// modulo 2^WIDTH. The last flag marks the final vector of a sweep (A == 0).
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load            load a_init/b_init into the operand registers
//   step            advance to the next vector (A-1, B+1)
//   a_init, b_init  first operand pair of a sweep
//   cmp_a, cmp_b    registered operands to the comparator
//   last            current vector is the final one of the sweep
module bist_vec_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_init,
  input  logic [WIDTH-1:0] b_init,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic             last
);

  // Load has priority over step so a restart from DONE always begins cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_a <= '0;
      cmp_b <= '0;
    end else if (load) begin
      cmp_a <= a_init;
      cmp_b <= b_init;
    end else if (step) begin
      cmp_a <= cmp_a - WIDTH'(1);
      cmp_b <= cmp_b + WIDTH'(1);
    end
  end

  assign last = (cmp_a == '0);

endmodule

// File: rtl/comparator_bist.sv
// comparator_bist
// Built-in self-test engine for the execute-stage magnitude comparator.
// Sweeps A downward and B upward one vector per cycle and checks the
// comparator result against the golden rule (A > B, unsigned). It reports
// busy/done, pass, a saturating error count, the number of vectors checked
// and the first failing operand pair.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           begin a sweep (honoured in IDLE or DONE only)
//   stop_on_fail    end the sweep at the first mismatch
//   a_init, b_init  first operand pair, sampled on the start edge
//   cmp_a, cmp_b    registered operands to the comparator
//   cmp_out         comparator result for cmp_a/cmp_b (same cycle)
//   busy, done      RUN / DONE status
//   pass            valid with done; high when no mismatch was seen
//   err_cnt         mismatch count, saturating
//   vec_cnt         number of vectors checked
//   fail_a, fail_b  operands of the first mismatch (0 if none)
module comparator_bist
  import comparator_bist_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter bit CHECK_EQ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_on_fail,
  input  logic [WIDTH-1:0] a_init,
  input  logic [WIDTH-1:0] b_init,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_cnt,
  output logic [WIDTH:0]   vec_cnt,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  state_t state;
  state_t state_nxt;

  logic load;
  logic step;
  logic last;
  logic expected;
  logic checked;
  logic mismatch;
  logic finish;

  bist_vec_gen #(
    .WIDTH (WIDTH)
  ) u_vec_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .a_init (a_init),
    .b_init (b_init),
    .cmp_a  (cmp_a),
    .cmp_b  (cmp_b),
    .last   (last)
  );

  // Golden compare and sweep control. Equal operands expect 0; when
  // CHECK_EQ is clear they are still counted as vectors but never flagged.
  // The final vector does not step, so cmp_a/cmp_b hold it in DONE.
  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    expected = 1'b0;
    checked  = 1'b0;
    mismatch = 1'b0;
    finish   = 1'b0;

    load     = start && (state != RUN);
    expected = (cmp_a > cmp_b);
    checked  = CHECK_EQ || (cmp_a != cmp_b);
    if (state == RUN) begin
      mismatch = checked && (cmp_out != expected);
      finish   = last || (mismatch && stop_on_fail);
      step     = !finish;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = RUN;
      RUN:     if (finish) state_nxt = DONE;
      DONE:    if (start)  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers. The first-failure capture keys off the count before
  // this vector, so only the very first mismatch of a sweep is recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
      vec_cnt <= '0;
      fail_a  <= '0;
      fail_b  <= '0;
    end else if (load) begin
      err_cnt <= '0;
      vec_cnt <= '0;
      fail_a  <= '0;
      fail_b  <= '0;
    end else if (state == RUN) begin
      vec_cnt <= vec_cnt + (WIDTH+1)'(1);
      if (mismatch) begin
        if (err_cnt != ERR_MAX) begin
          err_cnt <= err_cnt + 16'd1;
        end
        if (err_cnt == '0) begin
          fail_a <= cmp_a;
          fail_b <= cmp_b;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == '0);

endmodule
